lcd_text_writer: RTL and testbench
==================================

Name: lcd_text_writer

Overview:
Reader/sequencer for the 32-character text ROM that drives the DE2-115 HD44780-style character LCD. After reset it runs the LCD power-up and init command sequence. It then reads ROM addresses 0..15 into LCD line 1 and 16..31 into line 2, and idles with the display static. A refresh pulse rewrites both lines from the ROM without re-initialising.

Parameters:
POWERUP_CYCLES, 750000, clocks to wait after reset before the first command (15 ms at 50 MHz)
SETUP_CYCLES, 2, clocks lcd_rs/lcd_data are stable with lcd_en low before the enable pulse
EN_CYCLES, 12, clocks lcd_en is held high per write
WAIT_CYCLES, 2500, clocks after lcd_en falls before the next write (50 us)
CLEAR_CYCLES, 100000, post-write wait used for the clear-display command only (2 ms)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
refresh  input  1  single-cycle pulse; rewrite text when idle
rom_addr  output  5  character ROM address
rom_data  input  8  ASCII byte from ROM (combinational in rom_addr)
lcd_data  output  8  LCD data bus
lcd_rs  output  1  0 = command, 1 = character data
lcd_rw  output  1  always 0 (write only)
lcd_en  output  1  LCD enable strobe
lcd_on  output  1  LCD power; 1 when out of reset
busy  output  1  1 while any sequence is in progress
done  output  1  1 while idle with text written

Behaviour:
- Reset (async, active-high) values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, rom_addr=0, lcd_on=0, busy=1, done=0, state=POWERUP, all counters cleared.
- Reset mid-write forces lcd_en low immediately, with no completion of the pulse. The sequence restarts from POWERUP.
- The first clock after reset release sets lcd_on=1. It stays 1.
- POWERUP: count POWERUP_CYCLES clocks, then start the write list.
- Write list, in order. Init writes are rs=0; character writes are rs=1.
  - 0x38 function set (8-bit, 2 lines, 5x8).
  - 0x0C display on, cursor off.
  - 0x01 clear display.
  - 0x06 entry mode, increment.
  - 0x80 DDRAM address to line 1.
  - 16 characters from rom_addr 0..15.
  - 0xC0 DDRAM address to line 2.
  - 16 characters from rom_addr 16..31.
  - The full list is 38 writes.
- Each write is a three-phase micro-sequence:
  - SETUP: lcd_rs and lcd_data are driven, lcd_en=0, for SETUP_CYCLES.
  - PULSE: lcd_en=1 for EN_CYCLES.
  - HOLD/WAIT: lcd_en=0 with data unchanged, for WAIT_CYCLES, or CLEAR_CYCLES after 0x01.
  - lcd_data and lcd_rs must not change while lcd_en=1, or on the cycle lcd_en falls.
- ROM access:
  - rom_addr is registered and is updated at least one clock before a character write's SETUP phase begins.
  - lcd_data is captured from rom_data at SETUP entry.
  - rom_addr increments once per character write. It wraps 31->0 after the last character.
- IDLE: on entry busy=0 and done=1. lcd_data and lcd_rs hold their last values; lcd_en=0.
- refresh while IDLE: on the next clock busy=1 and done=0, rom_addr=0. The sequence restarts at the 0x80 write, so it is 34 writes with no init and no clear.
- refresh while busy is ignored and not queued.
- Counters are wide enough for the largest parameter: $clog2(max+1) bits. A parameter value of 0 is treated as 1.

Optional Feature:
LCD_CURSOR_BLINK_EN
- Defined: the display-control write is 0x0F (display on, cursor on, blink on).
- After text completes, one extra command write 0x80|0x4F (0xCF) parks the cursor at line 2, column 15 before IDLE.
- Full list becomes 39 writes; refresh becomes 35 writes.
- Undefined: 0x0C as above, and no park write.

Test Plan:
- Params POWERUP=10, SETUP=2, EN=3, WAIT=5, CLEAR=20; release reset at t0 -> lcd_on=1 at t0+1. First lcd_en rise at t0+10+2 (+/-1 for registration) with lcd_data=0x38, rs=0. lcd_en is high for exactly 3 clocks.
- Same params, ROM model giving "Hello"/"World" padded with spaces -> LCD monitor captures 38 writes in order. Line 1 = "Hello" plus 11 spaces; line 2 = "World" plus 11 spaces. The gap after the 0x01 write is 20 clocks; other gaps are 5. busy falls and done rises after the last write.
- refresh pulse while done=1 -> 34 writes starting 0x80 with no 0x38/0x0C/0x01/0x06. rom_addr sequence is 0..31. done=1 at end.
- refresh pulsed during the 10th character write -> no extra writes. The total write count is unchanged at 38.
- reset asserted while lcd_en=1 -> lcd_en=0 in the same cycle, without waiting for a clock. After release, the full sequence restarts from POWERUP with the 0x38 write first.
- With LCD_CURSOR_BLINK_EN defined -> second write is 0x0F. Final write is 0xCF with rs=0. The total is 39 writes.

Source files
------------

// File: rtl/lcd_text_writer.sv
// Power-up/init sequencer and 32-character text writer for an HD44780-style LCD.
// Optional `LCD_CURSOR_BLINK_EN`: blinking cursor plus a final cursor-park write.
module lcd_text_writer #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned EN_CYCLES      = 12,
    parameter int unsigned WAIT_CYCLES    = 2500,
    parameter int unsigned CLEAR_CYCLES   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       busy,
    output logic       done
);

    // A zero-length phase would never terminate; clamp every duration to at least one clock.
    localparam int unsigned PWR_N   = (POWERUP_CYCLES == 0) ? 1 : POWERUP_CYCLES;
    localparam int unsigned SETUP_N = (SETUP_CYCLES == 0)   ? 1 : SETUP_CYCLES;
    localparam int unsigned EN_N    = (EN_CYCLES == 0)      ? 1 : EN_CYCLES;
    localparam int unsigned WAIT_N  = (WAIT_CYCLES == 0)    ? 1 : WAIT_CYCLES;
    localparam int unsigned CLEAR_N = (CLEAR_CYCLES == 0)   ? 1 : CLEAR_CYCLES;

    localparam int unsigned MAX_A = (PWR_N > SETUP_N) ? PWR_N : SETUP_N;
    localparam int unsigned MAX_B = (EN_N > WAIT_N) ? EN_N : WAIT_N;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_N = (MAX_C > CLEAR_N) ? MAX_C : CLEAR_N;
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_N - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_N - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_N - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Write list index: 0..4 init + line-1 address, 5..20 line 1, 21 line-2 address, 22..37 line 2.
    localparam logic [5:0] STEP_CLEAR = 6'd2;
    localparam logic [5:0] STEP_LINE1 = 6'd4;
    localparam logic [5:0] STEP_LINE2 = 6'd21;
`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CTRL  = 8'h0F;
    localparam logic [5:0] LAST_STEP  = 6'd38;
`else
    localparam logic [7:0] DISP_CTRL  = 8'h0C;
    localparam logic [5:0] LAST_STEP  = 6'd37;
`endif

    typedef enum logic [2:0] {
        S_POWERUP,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       step_q, step_d;
    logic [4:0]       rom_addr_q, rom_addr_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;
    logic             lcd_on_q, lcd_on_d;

    logic             load;
    logic [5:0]       load_step;
    logic [CNT_W-1:0] wait_last;

    function automatic logic is_char_step(input logic [5:0] s);
        return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= 6'd37));
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [5:0] s);
        logic [7:0] b;
        case (s)
            6'd0:       b = 8'h38;
            6'd1:       b = DISP_CTRL;
            STEP_CLEAR: b = 8'h01;
            6'd3:       b = 8'h06;
            STEP_LINE1: b = 8'h80;
            STEP_LINE2: b = 8'hC0;
            6'd38:      b = 8'hCF;
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        rom_addr_d = rom_addr_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_en_d   = lcd_en_q;
        lcd_on_d   = 1'b1;
        load       = 1'b0;
        load_step  = step_q;
        wait_last  = (step_q == STEP_CLEAR) ? CLEAR_LAST : WAIT_LAST;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    load      = 1'b1;
                    load_step = 6'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d  = S_PULSE;
                    cnt_d    = '0;
                    lcd_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d  = S_WAIT;
                    cnt_d    = '0;
                    lcd_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        load      = 1'b1;
                        load_step = step_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_IDLE: begin
                if (refresh) begin
                    load       = 1'b1;
                    load_step  = STEP_LINE1;
                    rom_addr_d = '0;
                end
            end
            default: begin
                state_d = S_POWERUP;
                cnt_d   = '0;
            end
        endcase

        // Entering SETUP latches the bus; the ROM address advances right after a character is taken,
        // so it is settled long before the next character's SETUP edge.
        if (load) begin
            state_d  = S_SETUP;
            cnt_d    = '0;
            step_d   = load_step;
            lcd_en_d = 1'b0;
            if (is_char_step(load_step)) begin
                lcd_rs_d   = 1'b1;
                lcd_data_d = rom_data;
                rom_addr_d = rom_addr_q + 5'd1;
            end else begin
                lcd_rs_d   = 1'b0;
                lcd_data_d = cmd_byte(load_step);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_POWERUP;
            cnt_q      <= '0;
            step_q     <= '0;
            rom_addr_q <= '0;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            lcd_on_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            rom_addr_q <= rom_addr_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_en_q   <= lcd_en_d;
            lcd_on_q   <= lcd_on_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign lcd_data = lcd_data_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = lcd_en_q;
    assign lcd_on   = lcd_on_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_IDLE);

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: expected LCD writes are queued from a list model,
// a negedge monitor pops and checks every enable pulse, its width and the gaps between pulses.
module tb_lcd_text_writer;

    localparam int unsigned P_PWR   = 10;
    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EN    = 3;
    localparam int unsigned P_WAIT  = 5;
    localparam int unsigned P_CLEAR = 20;
`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0]  DISP   = 8'h0F;
    localparam int unsigned N_FULL = 39;
    localparam int unsigned N_REF  = 35;
`else
    localparam logic [7:0]  DISP   = 8'h0C;
    localparam int unsigned N_FULL = 38;
    localparam int unsigned N_REF  = 34;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh = 1'b0;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, busy, done;
    logic [7:0] rom_mem [32];

    assign rom_data = rom_mem[rom_addr];
    always #5 clk = ~clk;

    lcd_text_writer #(
        .POWERUP_CYCLES(P_PWR),
        .SETUP_CYCLES  (P_SETUP),
        .EN_CYCLES     (P_EN),
        .WAIT_CYCLES   (P_WAIT),
        .CLEAR_CYCLES  (P_CLEAR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .refresh (refresh),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en),
        .lcd_on  (lcd_on),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        int unsigned gap;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned total_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the write list as the LCD should receive it.
    task automatic push_wr(input logic rs, input logic [7:0] d, input int unsigned g);
        wr_t w;
        w.rs = rs; w.data = d; w.gap = g;
        exp_q.push_back(w);
    endtask

    task automatic push_text();
        push_wr(1'b0, 8'h80, P_WAIT);
        for (int i = 0; i < 16; i++) push_wr(1'b1, rom_mem[i], P_WAIT);
        push_wr(1'b0, 8'hC0, P_WAIT);
        for (int i = 16; i < 32; i++) push_wr(1'b1, rom_mem[i], P_WAIT);
`ifdef LCD_CURSOR_BLINK_EN
        push_wr(1'b0, 8'hCF, P_WAIT);
`endif
    endtask

    task automatic push_full();
        push_wr(1'b0, 8'h38, P_WAIT);
        push_wr(1'b0, DISP,  P_WAIT);
        push_wr(1'b0, 8'h01, P_CLEAR);
        push_wr(1'b0, 8'h06, P_WAIT);
        push_text();
    endtask

    // Monitor
    logic        prev_en = 1'b0;
    bit          gap_valid = 1'b0;
    int unsigned hi_cnt = 0, gap_cnt = 0, last_gap = 0;
    logic [7:0]  cap_data;
    logic        cap_rs;
    wr_t         cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_en   = 1'b0;
            gap_valid = 1'b0;
            hi_cnt    = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                total_writes++;
                if (gap_valid) check("gap_before_write", gap_cnt, last_gap + P_SETUP);
                check("rw_low", {31'd0, lcd_rw}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got rs=%0d data=0x%02h, none expected", lcd_rs, lcd_data);
                    last_gap = P_WAIT;
                end else begin
                    cur = exp_q.pop_front();
                    check("write_rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
                    check("write_data", {24'd0, lcd_data}, {24'd0, cur.data});
                    last_gap = cur.gap;
                end
                cap_data = lcd_data;
                cap_rs   = lcd_rs;
                hi_cnt   = 1;
            end else if (lcd_en) begin
                hi_cnt++;
                check("bus_stable_en", {23'd0, lcd_rs, lcd_data}, {23'd0, cap_rs, cap_data});
            end else if (prev_en) begin
                check("en_width", hi_cnt, P_EN);
                check("bus_stable_fall", {23'd0, lcd_rs, lcd_data}, {23'd0, cap_rs, cap_data});
                gap_cnt   = 1;
                gap_valid = 1'b1;
            end else begin
                gap_cnt++;
            end
            if (done) gap_valid = 1'b0;
            prev_en = lcd_en;
        end
    end

    task automatic check_reset_vals();
        check("rst_en",   {31'd0, lcd_en},   32'd0);
        check("rst_rs",   {31'd0, lcd_rs},   32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'd0);
        check("rst_addr", {27'd0, rom_addr}, 32'd0);
        check("rst_on",   {31'd0, lcd_on},   32'd0);
        check("rst_busy", {31'd0, busy},     32'd1);
        check("rst_done", {31'd0, done},     32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(posedge clk);
        #1 refresh = 1'b1;
        @(posedge clk);
        #1 refresh = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned base, input int unsigned n_exp);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done still 0 after 5000 cycles", name);
        end
        @(negedge clk);
        check({name, "_writes"}, total_writes - base, n_exp);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_en_low"}, {31'd0, lcd_en}, 32'd0);
        check({name, "_addr_wrap"}, {27'd0, rom_addr}, 32'd0);
    endtask

    task automatic wait_writes(input int unsigned base, input int unsigned n, input bit need_en);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ((total_writes - base >= n) && (!need_en || lcd_en)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_writes_timeout: only %0d of %0d writes seen", total_writes - base, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string       s1, s2;
        int unsigned n;
        int unsigned base;

        s1 = "Hello";
        s2 = "World";
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'h20;
        for (int i = 0; i < s1.len(); i++) rom_mem[i] = s1[i];
        for (int i = 0; i < s2.len(); i++) rom_mem[16 + i] = s2[i];

        // Reset state and power-up timing
        repeat (3) @(posedge clk);
        #1 check_reset_vals();
        push_full();
        base = total_writes;
        release_reset();
        check("on_before_clock", {31'd0, lcd_on}, 32'd0);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("on_after_first_clock", {31'd0, lcd_on}, 32'd1);
            if (lcd_en) begin
                n = i;
                break;
            end
        end
        checks++;
        if (!(n >= 11 && n <= 13)) begin
            errors++;
            $display("FAIL first_en_rise: got %0d cycles expected 12 (+/-1)", n);
        end
        wait_done("full_init", base, N_FULL);

        // Refresh from idle: text only
        push_text();
        base = total_writes;
        pulse_refresh();
        check("refresh_busy", {31'd0, busy}, 32'd1);
        check("refresh_done", {31'd0, done}, 32'd0);
        check("refresh_addr", {27'd0, rom_addr}, 32'd0);
        wait_done("refresh", base, N_REF);

        // Refresh during the 10th character write is ignored
        reset = 1'b1;
        exp_q.delete();
        push_full();
        release_reset();
        base = total_writes;
        wait_writes(base, 15, 1'b0);
        pulse_refresh();
        wait_done("busy_refresh", base, N_FULL);

        // Reset while lcd_en is high
        reset = 1'b1;
        exp_q.delete();
        push_full();
        release_reset();
        base = total_writes;
        wait_writes(base, 3, 1'b1);
        #1 reset = 1'b1;
        #1 check("async_en_drop", {31'd0, lcd_en}, 32'd0);
        @(posedge clk);
        #1 check_reset_vals();
        exp_q.delete();
        push_full();
        release_reset();
        base = total_writes;
        wait_done("after_reset", base, N_FULL);

        // Random ROM contents, refresh, and stray refresh pulses while busy
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 32; i++) rom_mem[i] = 8'($urandom);
            push_text();
            base = total_writes;
            pulse_refresh();
            repeat ($urandom_range(5, 200)) @(posedge clk);
            pulse_refresh();
            wait_done("random_refresh", base, N_REF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
